// File: rtl/video_scanout.sv
// Raster reader for the 1-bit frame buffer: walks the frame in row-major order,
// reads each pixel and streams it with its coordinates through a 2-entry FIFO.
module video_scanout #(
  parameter int WIDTH  = 500,
  parameter int HEIGHT = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt,
  output logic        rd_en,
  output logic [11:0] rd_x,
  output logic [11:0] rd_y,
  input  logic        rd_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_data,
  output logic [11:0] px_x,
  output logic [11:0] px_y,
  output logic        px_eol,
  output logic        px_eof
);

  localparam logic [11:0] X_LAST = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic        data;
    logic [11:0] x;
    logic [11:0] y;
    logic        eol;
    logic        eof;
  } entry_t;

  state_t      state_reg, state_next;
  logic [11:0] x_reg, y_reg;
  logic        load_addr;
  logic        inflight_reg;
  logic [11:0] cap_x_reg, cap_y_reg;
  logic        cap_eol_reg, cap_eof_reg;
  logic [1:0]  count_reg;
  entry_t      head_reg, tail_reg, new_entry;
  logic        done_reg;
  logic [7:0]  frame_cnt_reg;
  logic        push, pop, credit_ok, last_addr, frame_end;
  logic [2:0]  occ;

  assign pop       = px_valid & px_ready;
  assign push      = inflight_reg;
  // A pop in this cycle frees a slot, so it counts toward the credit; this keeps
  // a full 1 pixel/cycle stream with only two slots of storage.
  assign occ       = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign credit_ok = (occ < 3'd2);
  assign last_addr = (x_reg == X_LAST) && (y_reg == Y_LAST);
  assign frame_end = (state_reg == DRAIN) && pop && head_reg.eof;

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    load_addr  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load_addr  = 1'b1;
        end
      end
      RUN: begin
        rd_en = credit_ok;
        if (credit_ok && last_addr) state_next = DRAIN;
      end
      DRAIN: begin
        if (frame_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (load_addr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (rd_en) begin
      if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_LAST) ? 12'd0 : y_reg + 12'd1;
      end else begin
        x_reg <= x_reg + 12'd1;
      end
    end
  end

  // Coordinates travel alongside the read so the returning data can be tagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      cap_x_reg    <= '0;
      cap_y_reg    <= '0;
      cap_eol_reg  <= 1'b0;
      cap_eof_reg  <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      if (rd_en) begin
        cap_x_reg   <= x_reg;
        cap_y_reg   <= y_reg;
        cap_eol_reg <= (x_reg == X_LAST);
        cap_eof_reg <= last_addr;
      end
    end
  end

  assign new_entry = '{data: rd_data, x: cap_x_reg, y: cap_y_reg,
                       eol: cap_eol_reg, eof: cap_eof_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= new_entry;
          else                   tail_reg <= new_entry;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) head_reg <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_reg <= new_entry;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      done_reg <= frame_end;
      if (frame_end) frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign frame_cnt = frame_cnt_reg;
  assign rd_x      = x_reg;
  assign rd_y      = y_reg;
  assign px_valid  = (count_reg != 2'd0);
  assign px_data   = head_reg.data;
  assign px_x      = head_reg.x;
  assign px_y      = head_reg.y;
  assign px_eol    = head_reg.eol;
  assign px_eof    = head_reg.eof;

endmodule
